code_seq_3bit: RTL and testbench

Sequencer that produces the 3-bit code driving the 3-to-7 decoder stage: a start/stop controlled up/down code counter with programmable step rate, range limit, load and wrap reporting. It sits directly upstream of the decoder, and its `count` output connects straight to the decoder input. It replaces the free-running 3-bit enable counter wherever controlled stepping is needed.

---
 rtl/code_seq_pkg.sv | 23 ++
 rtl/code_seq_tick.sv | 40 ++++
 rtl/code_seq_3bit.sv | 120 ++++++++++++
 tb/tb_code_seq_3bit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/code_seq_pkg.sv
// Shared types and constants for the 3-bit code sequencer.
// Optional one-shot stop on wrap is enabled by CODE_SEQ_ONESHOT_EN.
package code_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam int CODE_W       = 3;
  localparam int PRE_W        = 8;
  localparam int DEF_PRESCALE = 4;
  localparam int DEF_MAX_CODE = 6;

  function automatic logic [CODE_W-1:0] clamp_code(
    input logic [CODE_W-1:0] v,
    input logic [CODE_W-1:0] lim
  );
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/code_seq_tick.sv
// Step-rate prescaler: tick fires on the last count of each period.
// Part of code_seq_3bit (optional macro CODE_SEQ_ONESHOT_EN).
module code_seq_tick
  import code_seq_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [PRE_W-1:0] LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/code_seq_3bit.sv
// Start/stop up/down 3-bit code sequencer feeding the 3-to-7 decoder.
// Define CODE_SEQ_ONESHOT_EN to add the oneshot input (stop on wrap).
module code_seq_3bit
  import code_seq_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int MAX_CODE = DEF_MAX_CODE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              count_enb,
  input  logic              start,
  input  logic              stop,
  input  logic              dir,
  input  logic              load,
  input  logic [CODE_W-1:0] load_val,
`ifdef CODE_SEQ_ONESHOT_EN
  input  logic              oneshot,
`endif
  output logic [CODE_W-1:0] count,
  output logic              wrap,
  output logic              busy
);

  localparam logic [CODE_W-1:0] MAXC = CODE_W'(MAX_CODE);

  state_e            state_q, state_d;
  logic [CODE_W-1:0] count_q, count_d;
  logic              wrap_q, wrap_d;
  logic              os;
  logic              tick;
  logic              pre_clr;
  logic              pre_en;
  logic              step;
  logic              at_end;

`ifdef CODE_SEQ_ONESHOT_EN
  assign os = oneshot;
`else
  assign os = 1'b0;
`endif

  // PAUSE with count_enb back high already counts, so a pause costs
  // exactly the cycles count_enb was low.
  assign pre_en  = count_enb && (state_q != IDLE);
  assign pre_clr = load || stop || (state_q == IDLE);
  assign step    = tick && !load && !stop;
  assign at_end  = dir ? (count_q == MAXC)
                       : (count_q == '0);

  code_seq_tick #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (pre_clr),
    .en   (pre_en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = state_q;
    end else if (stop) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN:     if (!count_enb) state_d = PAUSE;
        PAUSE:   if (count_enb) state_d = RUN;
        default: state_d = IDLE;
      endcase
      if (step && at_end && os) state_d = IDLE;
    end
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = clamp_code(load_val, MAXC);
    end else if (step) begin
      if (at_end) begin
        count_d = dir ? '0 : MAXC;
        wrap_d  = 1'b1;
      end else if (dir) begin
        count_d = count_q + CODE_W'(1);
      end else begin
        count_d = count_q - CODE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_code_seq_3bit.sv
// Scoreboard bench for code_seq_3bit at default parameters.
// Define CODE_SEQ_ONESHOT_EN to also exercise the oneshot input.
module tb_code_seq_3bit;

  logic       clk;
  logic       reset;
  logic       count_enb;
  logic       start;
  logic       stop;
  logic       dir;
  logic       load;
  logic [2:0] load_val;
  logic [2:0] count;
  logic       wrap;
  logic       busy;
`ifdef CODE_SEQ_ONESHOT_EN
  logic       oneshot;
`endif

  typedef struct packed {
    logic [2:0] c;
    logic       w;
    logic       b;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  code_seq_3bit dut (
    .clk      (clk),
    .reset    (reset),
    .count_enb(count_enb),
    .start    (start),
    .stop     (stop),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
`ifdef CODE_SEQ_ONESHOT_EN
    .oneshot  (oneshot),
`endif
    .count    (count),
    .wrap     (wrap),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b0; start = 1'b1; count_enb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sbq.push_back(exp_t'{c: 3'd0, w: 1'b0, b: 1'b0});
      cyc();
      e = sbq.pop_front(); checks++;
      if ({count, wrap, busy} !== e) begin
        errors++;
        $display("FAIL reset i=%0d got c=%0d w=%b b=%b exp c=%0d w=%b b=%b",
                 i, count, wrap, busy, e.c, e.w, e.b);
      end
    end
    for (int i = 0; i < 2; i++) begin
      reset = 1'b1;
      start = (i == 0);
      stop  = (i == 1);
      sbq.push_back(exp_t'{c: 3'd0, w: 1'b0, b: (i == 0)});
      cyc();
      e = sbq.pop_front(); checks++;
      if ({count, wrap, busy} !== e) begin
        errors++;
        $display("FAIL release i=%0d got c=%0d w=%b b=%b exp c=%0d w=%b b=%b",
                 i, count, wrap, busy, e.c, e.w, e.b);
      end
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_up_wrap();
    exp_t e;
    dir = 1'b1; count_enb = 1'b1;
    for (int k = 0; k <= 31; k++) begin
      start = (k == 0);
      stop  = (k == 31);
      if (k == 31)
        sbq.push_back(exp_t'{c: 3'd0, w: 1'b0, b: 1'b0});
      else
        sbq.push_back(exp_t'{c: 3'((k / 4) % 7), w: (k == 28), b: 1'b1});
      cyc();
      e = sbq.pop_front(); checks++;
      if ({count, wrap, busy} !== e) begin
        errors++;
        $display("FAIL up_wrap k=%0d got c=%0d w=%b b=%b exp c=%0d w=%b b=%b",
                 k, count, wrap, busy, e.c, e.w, e.b);
      end
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_down_pause();
    exp_t e;
    logic [2:0] c;
    dir = 1'b0; load = 1'b1; load_val = 3'd2;
    sbq.push_back(exp_t'{c: 3'd2, w: 1'b0, b: 1'b0});
    cyc();
    load = 1'b0;
    e = sbq.pop_front(); checks++;
    if ({count, wrap, busy} !== e) begin
      errors++;
      $display("FAIL down_load got c=%0d w=%b b=%b exp c=%0d w=%b b=%b",
               count, wrap, busy, e.c, e.w, e.b);
    end
    for (int k = 0; k <= 25; k++) begin
      start     = (k == 0);
      stop      = (k == 25);
      count_enb = !(k >= 7 && k <= 16);
      c = (k < 4) ? 3'd2 : (k < 18) ? 3'd1 : (k < 22) ? 3'd0 : 3'd6;
      sbq.push_back(exp_t'{c: c, w: (k == 22), b: (k != 25)});
      cyc();
      e = sbq.pop_front(); checks++;
      if ({count, wrap, busy} !== e) begin
        errors++;
        $display("FAIL down_pause k=%0d got c=%0d w=%b b=%b exp c=%0d w=%b b=%b",
                 k, count, wrap, busy, e.c, e.w, e.b);
      end
    end
    start = 1'b0; stop = 1'b0; count_enb = 1'b1;
  endtask

  task automatic test_load_clamp();
    exp_t e;
    logic [2:0] c;
    dir = 1'b1; count_enb = 1'b1;
    for (int k = -1; k <= 10; k++) begin
      load     = (k == -1) || (k == 4);
      load_val = (k == -1) ? 3'd0 : 3'd7;
      start    = (k == 0);
      stop     = (k == 10);
      c = (k < 4) ? 3'd0 : (k < 8) ? 3'd6 : 3'd0;
      sbq.push_back(exp_t'{c: c, w: (k == 8), b: (k >= 0 && k < 10)});
      cyc();
      e = sbq.pop_front(); checks++;
      if ({count, wrap, busy} !== e) begin
        errors++;
        $display("FAIL load_clamp k=%0d got c=%0d w=%b b=%b exp c=%0d w=%b b=%b",
                 k, count, wrap, busy, e.c, e.w, e.b);
      end
    end
    load = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_stop_restart();
    exp_t e;
    logic [2:0] c;
    dir = 1'b1; count_enb = 1'b1;
    for (int k = -1; k <= 16; k++) begin
      start = (k <= 0);
      stop  = (k == -1) || (k == 14);
      c = (k < 14) ? 3'((k < 0) ? 0 : k / 4) : 3'd3;
      sbq.push_back(exp_t'{c: c, w: 1'b0, b: (k >= 0 && k < 14)});
      cyc();
      e = sbq.pop_front(); checks++;
      if ({count, wrap, busy} !== e) begin
        errors++;
        $display("FAIL stop k=%0d got c=%0d w=%b b=%b exp c=%0d w=%b b=%b",
                 k, count, wrap, busy, e.c, e.w, e.b);
      end
    end
    for (int k = 0; k <= 6; k++) begin
      start = (k == 0);
      stop  = (k == 6);
      c = (k < 4) ? 3'd3 : 3'd4;
      sbq.push_back(exp_t'{c: c, w: 1'b0, b: (k != 6)});
      cyc();
      e = sbq.pop_front(); checks++;
      if ({count, wrap, busy} !== e) begin
        errors++;
        $display("FAIL restart k=%0d got c=%0d w=%b b=%b exp c=%0d w=%b b=%b",
                 k, count, wrap, busy, e.c, e.w, e.b);
      end
    end
    start = 1'b0; stop = 1'b0;
  endtask

`ifdef CODE_SEQ_ONESHOT_EN
  task automatic test_oneshot();
    exp_t e;
    logic [2:0] c;
    dir = 1'b1; count_enb = 1'b1; oneshot = 1'b1;
    for (int k = -1; k <= 11; k++) begin
      load     = (k == -1);
      load_val = 3'd5;
      start    = (k == 0);
      c = (k < 4) ? 3'd5 : (k < 8) ? 3'd6 : 3'd0;
      sbq.push_back(exp_t'{c: c, w: (k == 8), b: (k >= 0 && k < 8)});
      cyc();
      e = sbq.pop_front(); checks++;
      if ({count, wrap, busy} !== e) begin
        errors++;
        $display("FAIL oneshot k=%0d got c=%0d w=%b b=%b exp c=%0d w=%b b=%b",
                 k, count, wrap, busy, e.c, e.w, e.b);
      end
    end
    load = 1'b0; start = 1'b0; oneshot = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b0; count_enb = 1'b0; start = 1'b0; stop = 1'b0;
    dir = 1'b1; load = 1'b0; load_val = 3'd0;
`ifdef CODE_SEQ_ONESHOT_EN
    oneshot = 1'b0;
`endif
    #1;
    test_reset();
    test_up_wrap();
    test_down_pause();
    test_load_clamp();
    test_stop_restart();
`ifdef CODE_SEQ_ONESHOT_EN
    test_oneshot();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
